memory_stage: RTL and testbench

//   MEM stage of the 5-stage MIPS pipeline; consumes Execute's WDEM/RD2EM.

---
 rtl/memory_stage.sv | 129 ++++++++++++
 tb/tb_memory_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: E/M register, word-organised data memory, load/store unit.
// Optional store trace enabled with `define DM_DISPLAY_EN.
module memory_stage #(
  parameter int unsigned DM_WORDS = 4096,
  parameter int unsigned AW       = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrE,
  input  logic [31:0] PCE,
  input  logic [4:0]  A3E,
  input  logic [31:0] WDEM,
  input  logic [31:0] RD2EM,
  input  logic [31:0] FwdM2,
  output logic [31:0] InstrM,
  output logic [31:0] PCM,
  output logic [4:0]  A3M,
  output logic [31:0] FwdM,
  output logic [31:0] WDMW
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic [31:0]   dm [DM_WORDS];
  logic [31:0]   rd2m;
  logic [5:0]    op;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          is_store;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rword;
  logic [31:0]   merged;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;

  always_ff @(posedge clk) begin
    if (!reset) begin
      InstrM <= '0;
      PCM    <= '0;
      A3M    <= '0;
      FwdM   <= '0;
      rd2m   <= '0;
    end else begin
      InstrM <= InstrE;
      PCM    <= PCE;
      A3M    <= A3E;
      FwdM   <= WDEM;
      rd2m   <= RD2EM;
    end
  end

  // Registered RD2 is kept for pipeline completeness; store data comes via FwdM2.
  logic unused_rd2;
  assign unused_rd2 = ^rd2m;

  assign op    = InstrM[31:26];
  assign idx   = FwdM[AW+1:2];
  assign lane  = FwdM[1:0];
  assign rword = dm[idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = FwdM[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    is_store = 1'b0;
    be       = '0;
    wdata    = FwdM2;
    unique case (op)
      OP_SW: begin
        is_store = 1'b1;
        be       = '1;
      end
      OP_SH: begin
        is_store = 1'b1;
        be       = FwdM[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{FwdM2[15:0]}};
      end
      OP_SB: begin
        is_store = 1'b1;
        be       = 4'b0001 << lane;
        wdata    = {4{FwdM2[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    merged = rword;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  always_comb begin
    unique case (op)
      OP_LW:   WDMW = rword;
      OP_LH:   WDMW = {{16{rhalf[15]}}, rhalf};
      OP_LHU:  WDMW = {16'h0000, rhalf};
      OP_LB:   WDMW = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  WDMW = {24'h000000, rbyte};
      default: WDMW = FwdM;
    endcase
  end

  // Reset clears the whole array and takes priority over a store in M.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) dm[i[AW-1:0]] <= '0;
    end else if (is_store) begin
      dm[idx] <= merged;
    end
  end

`ifdef DM_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (reset && is_store)
      $display("%d@%h: *%h <= %h", $time, PCM, {FwdM[31:2], 2'b00}, merged);
  end
`else
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases plus randomized traffic
// against a byte-addressed reference memory.
module tb_memory_stage;
  localparam int unsigned DM_WORDS = 4096;
  localparam int unsigned AW       = 12;
  localparam int unsigned NB       = DM_WORDS * 4;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] InstrE = '0, PCE = '0, WDEM = '0, RD2EM = '0, FwdM2 = '0;
  logic [4:0]  A3E = '0;
  logic [31:0] InstrM, PCM, FwdM, WDMW;
  logic [4:0]  A3M;

  always #5 clk = ~clk;

  memory_stage #(.DM_WORDS(DM_WORDS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .InstrE(InstrE), .PCE(PCE), .A3E(A3E),
    .WDEM(WDEM), .RD2EM(RD2EM), .FwdM2(FwdM2), .InstrM(InstrM), .PCM(PCM),
    .A3M(A3M), .FwdM(FwdM), .WDMW(WDMW)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [NB];
  logic        pend = 1'b0;
  logic [5:0]  pop;
  logic [31:0] paddr, pdata;
  logic [31:0] e_instr = '0, e_pc = '0, e_fwd = '0;
  logic [4:0]  e_a3 = '0;

  function automatic logic [31:0] mk(input logic [5:0] op);
    logic [31:0] r;
    r = $urandom;
    return {op, r[25:0]};
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a);
    int unsigned b = a & (NB - 1);
    int unsigned w = b & ~32'd3;
    int unsigned h = b & ~32'd1;
    logic [15:0] hv;
    logic [7:0]  bv;
    hv = {mem[h + 1], mem[h]};
    bv = mem[b];
    case (op)
      LW:      return {mem[w + 3], mem[w + 2], mem[w + 1], mem[w]};
      LH:      return {{16{hv[15]}}, hv};
      LHU:     return {16'h0, hv};
      LB:      return {{24{bv[7]}}, bv};
      LBU:     return {24'h0, bv};
      default: return a;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op == SW || op == SH || op == SB;
  endfunction

  task automatic model_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    int unsigned b = a & (NB - 1);
    case (op)
      SW: for (int k = 0; k < 4; k++) mem[(b & ~32'd3) + k] = d[8*k +: 8];
      SH: begin
        mem[b & ~32'd1]         = d[7:0];
        mem[(b & ~32'd1) + 1]   = d[15:8];
      end
      SB: mem[b] = d[7:0];
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] instr, input logic [31:0] addr,
                      input logic [31:0] sdata, input string tag);
    logic [31:0] pc;
    logic [31:0] r;
    r  = $urandom;
    pc = {r[31:2], 2'b00};
    @(negedge clk);
    reset = rst; InstrE = instr; PCE = pc; A3E = r[6:2]; WDEM = addr; RD2EM = sdata;
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int i = 0; i < NB; i++) mem[i] = '0;
      pend = 1'b0;
      e_instr = '0; e_pc = '0; e_a3 = '0; e_fwd = '0;
    end else begin
      if (pend) model_store(pop, paddr, pdata);
      pend = 1'b0;
      e_instr = instr; e_pc = pc; e_a3 = r[6:2]; e_fwd = addr;
    end
    FwdM2 = sdata;
    chk({tag, ".InstrM"}, InstrM, e_instr);
    chk({tag, ".PCM"}, PCM, e_pc);
    chk({tag, ".A3M"}, {27'h0, A3M}, {27'h0, e_a3});
    chk({tag, ".FwdM"}, FwdM, e_fwd);
    chk({tag, ".WDMW"}, WDMW, model_load(e_instr[31:26], e_fwd));
    if (rst && is_store(instr[31:26])) begin
      pend = 1'b1; pop = instr[31:26]; paddr = addr; pdata = sdata;
    end
  endtask

  logic [5:0] ops [11] = '{LW, LH, LHU, LB, LBU, SW, SH, SB, 6'h00, 6'h08, 6'h0F};

  initial begin
    logic [31:0] a, d, hi;
    logic [5:0]  op;
    logic        rs;

    step(1'b0, mk(LW), 32'h0, 32'h0, "rst1");
    step(1'b0, mk(LW), 32'h0, 32'h0, "rst2");
    chk("rst.A3M", {27'h0, A3M}, 32'h0);
    chk("rst.WDMW", WDMW, 32'h0);
    step(1'b1, mk(LW), 32'h0, 32'h0, "lw0");
    chk("lw0.val", WDMW, 32'h0);
    step(1'b1, mk(LW), 32'h3FFC, 32'h0, "lw3ffc");
    chk("lw3ffc.val", WDMW, 32'h0);

    step(1'b1, mk(SW), 32'h10, 32'h12345678, "sw10");
    step(1'b1, mk(LW), 32'h10, 32'h0, "lw10");
    chk("raw.lw10", WDMW, 32'h12345678);

    step(1'b1, mk(SB), 32'h11, 32'h000000AB, "sb11");
    step(1'b1, mk(LB), 32'h11, 32'h0, "lb11");
    chk("lb11.val", WDMW, 32'hFFFFFFAB);
    step(1'b1, mk(LBU), 32'h11, 32'h0, "lbu11");
    chk("lbu11.val", WDMW, 32'h000000AB);
    step(1'b1, mk(LW), 32'h10, 32'h0, "sbword");
    chk("sbword.val", WDMW, 32'h1234AB78);

    step(1'b1, mk(SH), 32'h12, 32'h00008001, "sh12");
    step(1'b1, mk(LH), 32'h12, 32'h0, "lh12");
    chk("lh12.val", WDMW, 32'hFFFF8001);
    step(1'b1, mk(LHU), 32'h12, 32'h0, "lhu12");
    chk("lhu12.val", WDMW, 32'h00008001);
    step(1'b1, mk(LW), 32'h10, 32'h0, "shword");
    chk("shword.val", WDMW, 32'h8001AB78);

    step(1'b1, mk(SW), 32'h4010, 32'hDEADBEEF, "swwrap");
    step(1'b1, mk(LW), 32'h10, 32'h0, "lwwrap");
    chk("wrap.val", WDMW, 32'hDEADBEEF);

    step(1'b1, mk(SW), 32'h20, 32'hCAFEF00D, "swrst");
    step(1'b0, 32'h0, 32'h0, 32'h0, "rstw");
    step(1'b1, mk(LW), 32'h20, 32'h0, "lw20");
    chk("rstwins.val", WDMW, 32'h0);
    step(1'b1, mk(LW), 32'h10, 32'h0, "lw10c");
    chk("cleared.val", WDMW, 32'h0);
    step(1'b1, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'h55, 32'h77, "addu");
    chk("addu.val", WDMW, 32'h55);
    step(1'b1, mk(LW), 32'h54, 32'h0, "lw54");
    chk("addu.nomem", WDMW, 32'h0);

    for (int n = 0; n < 400; n++) begin
      op = ops[$urandom_range(0, 10)];
      hi = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_C000) : 32'h0;
      a  = hi | 32'($urandom_range(0, 63));
      d  = $urandom;
      rs = ($urandom_range(0, 60) != 0);
      step(rs, mk(op), a, d, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
